multicycle_controller: RTL and testbench

//   Multi-cycle RV32I control FSM for the shared-memory datapath, replacing single-cycle decode.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_alu_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// opcodes, function fields, FSM states and datapath mux codes.
package mc_ctrl_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JWB      = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14,
      S_EXEC_MUL = 4'd15
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_MUL  = 4'd8;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MEM    = 2'd1;
   localparam logic [1:0] RES_ALU    = 2'd2;
   localparam logic [1:0] RES_IMM    = 2'd3;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decoder for R-type and I-type ALU ops.
// Flags shifts and unknown func7 patterns as illegal.
module alu_decoder
   import mc_ctrl_pkg::*;
#(
   parameter int W = 3
) (
   input  logic [2:0]   func3,
   input  logic [6:0]   func7,
   input  logic         is_rtype,
   output logic [W-1:0] alu_ctl,
   output logic         illegal
);

   logic f7_ok;

   // I-type ignores func7; R-type allows only base, or alt with sub
   assign f7_ok = !is_rtype || (func7 == F7_BASE) ||
                  ((func7 == F7_ALT) && (func3 == F3_ADD));

   always_comb begin
      alu_ctl = W'(ALU_ADD);
      illegal = 1'b0;
      unique case (func3)
         F3_ADD:
            if (is_rtype && (func7 == F7_ALT))
               alu_ctl = W'(ALU_SUB);
         F3_SLT:  alu_ctl = W'(ALU_SLT);
         F3_SLTU: alu_ctl = W'(ALU_SLTU);
         F3_XOR:  alu_ctl = W'(ALU_XOR);
         F3_OR:   alu_ctl = W'(ALU_OR);
         F3_AND:  alu_ctl = W'(ALU_AND);
         default: illegal = 1'b1;
      endcase
      if (!f7_ok)
         illegal = 1'b1;
      if (illegal)
         alu_ctl = W'(ALU_ADD);
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with memory ready handshake and trap state.
// Define MUL_EXT_EN to add a fixed-latency EXEC_MUL state for mul.
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTL_W = 3,
   parameter int MUL_LAT  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          op,
   input  logic [2:0]          func3,
   input  logic [6:0]          func7,
   input  logic                zero,
   input  logic                lt,
   input  logic                ltu,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                MemWrite,
   output logic                AdrSrc,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                RegWrite,
   output logic [1:0]          ResultSrc,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic [2:0]          ImmSrc,
   output logic                illegal_instr
);

   state_t state, nxt;

   logic [ALUCTL_W-1:0] dec_ctl;
   logic                dec_ill;
   logic                taken;
   logic                br_ok;
   logic                is_mul;

   alu_decoder #(.W(ALUCTL_W)) u_dec (
      .func3    (func3),
      .func7    (func7),
      .is_rtype (op == OP_R),
      .alu_ctl  (dec_ctl),
      .illegal  (dec_ill)
   );

   always_comb begin
      taken = 1'b0;
      br_ok = 1'b1;
      unique case (func3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = ~lt;
         F3_BLTU: taken = ltu;
         F3_BGEU: taken = ~ltu;
         default: br_ok = 1'b0;
      endcase
   end

`ifdef MUL_EXT_EN
   logic [3:0] mul_cnt;

   assign is_mul = (op == OP_R) && (func7 == F7_MULDIV) &&
                   (func3 == F3_ADD);

   // counts remaining EXEC_MUL cycles; zero means the product is ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mul_cnt <= 4'd0;
      else if ((state == S_DECODE) && (nxt == S_EXEC_MUL))
         mul_cnt <= 4'(MUL_LAT - 1);
      else if ((state == S_EXEC_MUL) && (mul_cnt != 4'd0))
         mul_cnt <= mul_cnt - 4'd1;
   end
`else
   assign is_mul = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_FETCH;
      else
         state <= nxt;
   end

   always_comb begin
      nxt           = state;
      mem_req       = 1'b0;
      MemWrite      = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RS2;
      ALUControl    = ALUCTL_W'(ALU_ADD);
      ImmSrc        = IMM_I;
      illegal_instr = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               nxt     = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_R:    nxt = is_mul ? S_EXEC_MUL : S_EXEC_R;
               OP_I:    nxt = S_EXEC_I;
               OP_BR:   nxt = S_BRANCH;
               OP_JAL:  nxt = S_JAL;
               OP_JALR: nxt = S_JALR;
               OP_LUI:  nxt = S_LUI;
               default: nxt = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            nxt     = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready)
               nxt = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite  = 1'b1;
            ResultSrc = RES_MEM;
            nxt       = S_FETCH;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
            if (mem_ready)
               nxt = S_FETCH;
         end
         S_EXEC_R: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = dec_ctl;
            nxt        = dec_ill ? S_TRAP : S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = dec_ctl;
            nxt        = dec_ill ? S_TRAP : S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            nxt      = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = ALUCTL_W'(ALU_SUB);
            PCWrite    = taken && br_ok;
            nxt        = br_ok ? S_FETCH : S_TRAP;
         end
         S_JAL, S_JALR: begin
            ALUSrcA   = (state == S_JAL) ? SRCA_OLDPC : SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = (state == S_JAL) ? IMM_J : IMM_I;
            ResultSrc = RES_ALU;
            PCWrite   = 1'b1;
            nxt       = S_JWB;
         end
         S_JWB: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            RegWrite  = 1'b1;
            nxt       = S_FETCH;
         end
         S_LUI: begin
            ImmSrc    = IMM_U;
            ResultSrc = RES_IMM;
            RegWrite  = 1'b1;
            nxt       = S_FETCH;
         end
`ifdef MUL_EXT_EN
         S_EXEC_MUL: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = ALUCTL_W'(ALU_MUL);
            if (mul_cnt == 4'd0)
               nxt = S_ALUWB;
         end
`endif
         S_TRAP: illegal_instr = 1'b1;
         default: nxt = S_TRAP;
      endcase

      // reset drops every strobe immediately, including a pending request
      if (rst) begin
         mem_req       = 1'b0;
         MemWrite      = 1'b0;
         AdrSrc        = 1'b0;
         IRWrite       = 1'b0;
         PCWrite       = 1'b0;
         RegWrite      = 1'b0;
         ResultSrc     = RES_ALUOUT;
         ALUSrcA       = SRCA_PC;
         ALUSrcB       = SRCB_RS2;
         ALUControl    = ALUCTL_W'(ALU_ADD);
         ImmSrc        = IMM_I;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle tables
// compared every cycle, plus directed literal checks.
module tb_multicycle_controller;

`ifdef MUL_EXT_EN
   localparam int AW = 4;
   localparam bit MULX = 1'b1;
`else
   localparam int AW = 3;
   localparam bit MULX = 1'b0;
`endif
   localparam int ML = 4;

   typedef struct packed {
      logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
      logic [1:0] resultsrc, srca, srcb;
      logic [3:0] aluctl;
      logic [2:0] immsrc;
      logic       illegal;
   } outs_t;

   typedef struct {
      logic  rdy;
      outs_t o;
   } cyc_t;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          fd, md;
      logic [31:0] a, b;
      string       nm;
   } instr_t;

   logic clk, rst, zero, lt, ltu, mem_ready;
   logic [6:0] op, func7;
   logic [2:0] func3;
   logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [AW-1:0] ALUControl;
   logic [2:0] ImmSrc;
   logic illegal_instr;

   int checks = 0;
   int errors = 0;
   cyc_t exp_q[$];
   outs_t obs[64];

   multicycle_controller #(.ALUCTL_W(AW), .MUL_LAT(ML)) dut (
      .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .illegal_instr(illegal_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d got %h exp %h", nm, k, got, exp);
      end
   endtask

   function automatic outs_t get_obs();
      outs_t o;
      o.mem_req   = mem_req;
      o.memwrite  = MemWrite;
      o.adrsrc    = AdrSrc;
      o.irwrite   = IRWrite;
      o.pcwrite   = PCWrite;
      o.regwrite  = RegWrite;
      o.resultsrc = ResultSrc;
      o.srca      = ALUSrcA;
      o.srcb      = ALUSrcB;
      o.aluctl    = 4'(ALUControl);
      o.immsrc    = ImmSrc;
      o.illegal   = illegal_instr;
      return o;
   endfunction

   // ALU op table straight from the ISA: returns 0 for unsupported encodings
   function automatic bit exp_alu(bit isr, logic [2:0] f3, logic [6:0] f7,
                                  output logic [3:0] c);
      c = 4'd0;
      if (isr && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0)))
         return 1'b0;
      case (f3)
         3'd0: c = (isr && f7 == 7'h20) ? 4'd1 : 4'd0;
         3'd2: c = 4'd5;
         3'd3: c = 4'd6;
         3'd4: c = 4'd4;
         3'd6: c = 4'd3;
         3'd7: c = 4'd2;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   function automatic void push(logic r, outs_t o);
      exp_q.push_back('{rdy: r, o: o});
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void build(instr_t in);
      outs_t o;
      logic [3:0] c;
      bit ok, tk, trap, st, eq, slt, ult, jal;
      exp_q.delete();
      trap = 0;
      o = '0; o.mem_req = 1; o.srcb = 2; o.resultsrc = 2;
      for (int i = 0; i < in.fd; i++) push(1'b0, o);
      o.irwrite = 1; o.pcwrite = 1;
      push(1'b1, o);
      o = '0; o.srca = 1; o.srcb = 1; o.immsrc = 2;
      push(rnd(), o);
      o = '0;
      case (in.op)
         7'h33: begin
            if (MULX && in.f7 == 7'h01 && in.f3 == 3'd0) begin
               o.srca = 2; o.aluctl = 4'd8;
               for (int i = 0; i < ML; i++) push(rnd(), o);
               o = '0; o.regwrite = 1;
               push(rnd(), o);
            end else begin
               ok = exp_alu(1'b1, in.f3, in.f7, c);
               o.srca = 2; o.aluctl = c;
               push(rnd(), o);
               if (ok) begin
                  o = '0; o.regwrite = 1;
                  push(rnd(), o);
               end else trap = 1;
            end
         end
         7'h13: begin
            ok = exp_alu(1'b0, in.f3, in.f7, c);
            o.srca = 2; o.srcb = 1; o.aluctl = c;
            push(rnd(), o);
            if (ok) begin
               o = '0; o.regwrite = 1;
               push(rnd(), o);
            end else trap = 1;
         end
         7'h03, 7'h23: begin
            st = (in.op == 7'h23);
            o.srca = 2; o.srcb = 1; o.immsrc = {2'b0, st};
            push(rnd(), o);
            o = '0; o.mem_req = 1; o.adrsrc = 1; o.memwrite = st;
            for (int i = 0; i < in.md; i++) push(1'b0, o);
            push(1'b1, o);
            if (!st) begin
               o = '0; o.regwrite = 1; o.resultsrc = 1;
               push(rnd(), o);
            end
         end
         7'h63: begin
            eq  = (in.a == in.b);
            slt = ($signed(in.a) < $signed(in.b));
            ult = (in.a < in.b);
            ok = 1; tk = 0;
            case (in.f3)
               3'd0: tk = eq;
               3'd1: tk = !eq;
               3'd4: tk = slt;
               3'd5: tk = !slt;
               3'd6: tk = ult;
               3'd7: tk = !ult;
               default: ok = 0;
            endcase
            o.srca = 2; o.aluctl = 4'd1; o.pcwrite = tk;
            push(rnd(), o);
            trap = !ok;
         end
         7'h6f, 7'h67: begin
            jal = (in.op == 7'h6f);
            o.srca = jal ? 2'd1 : 2'd2; o.srcb = 1;
            o.immsrc = jal ? 3'd3 : 3'd0;
            o.resultsrc = 2; o.pcwrite = 1;
            push(rnd(), o);
            o = '0; o.srca = 1; o.srcb = 2; o.resultsrc = 2; o.regwrite = 1;
            push(rnd(), o);
         end
         7'h37: begin
            o.immsrc = 4; o.resultsrc = 3; o.regwrite = 1;
            push(rnd(), o);
         end
         default: trap = 1;
      endcase
      if (trap) begin
         o = '0; o.illegal = 1;
         for (int i = 0; i < 3; i++) push(rnd(), o);
      end
   endfunction

   task automatic do_reset(string nm);
      outs_t z;
      z = '0;
      mem_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk({nm, "_async"}, 0, get_obs(), z);
      @(negedge clk);
      chk({nm, "_hold"}, 1, get_obs(), z);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run(instr_t in, int limit);
      int n;
      outs_t got;
      build(in);
      op = in.op; func3 = in.f3; func7 = in.f7;
      zero = (in.a == in.b);
      lt   = ($signed(in.a) < $signed(in.b));
      ltu  = (in.a < in.b);
      n = (limit < exp_q.size()) ? limit : exp_q.size();
      for (int k = 0; k < n; k++) begin
         mem_ready = exp_q[k].rdy;
         @(negedge clk);
         got = get_obs();
         obs[k] = got;
         chk(in.nm, k, got, exp_q[k].o);
         @(posedge clk);
         #1;
      end
      if (n == exp_q.size() && exp_q[n-1].o.illegal)
         do_reset({in.nm, "_trap_rst"});
   endtask

   function automatic instr_t mk(logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                                 int fd, int md, logic [31:0] a, logic [31:0] b,
                                 string nm);
      instr_t r;
      r.op = o; r.f3 = f3; r.f7 = f7; r.fd = fd; r.md = md;
      r.a = a; r.b = b; r.nm = nm;
      return r;
   endfunction

   function automatic instr_t rand_instr();
      logic [2:0] alu_f3 [6];
      logic [2:0] br_f3 [6];
      logic [6:0] bad [3];
      logic [31:0] a, b;
      int fd, md;
      alu_f3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
      br_f3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      bad    = '{7'h00, 7'h7f, 7'h17};
      fd = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      case ($urandom_range(0, 8))
         0: return ($urandom_range(0, 3) == 0) ?
                   mk(7'h33, 3'd0, 7'h20, fd, md, a, b, "r_sub") :
                   mk(7'h33, alu_f3[$urandom_range(0, 5)], 7'h00,
                      fd, md, a, b, "r_alu");
         1: return mk(7'h13, alu_f3[$urandom_range(0, 5)],
                      7'($urandom), fd, md, a, b, "i_alu");
         2: return mk(7'h03, 3'd2, 7'($urandom), fd, md, a, b, "lw");
         3: return mk(7'h23, 3'd2, 7'($urandom), fd, md, a, b, "sw");
         4: return mk(7'h63, br_f3[$urandom_range(0, 5)], 7'($urandom),
                      fd, md, a, b, "br");
         5: return mk(7'h6f, 3'($urandom), 7'($urandom), fd, md, a, b, "jal");
         6: return mk(7'h67, 3'd0, 7'($urandom), fd, md, a, b, "jalr");
         7: return mk(7'h37, 3'($urandom), 7'($urandom), fd, md, a, b, "lui");
         default: return mk(bad[$urandom_range(0, 2)], 3'($urandom),
                            7'($urandom), fd, md, a, b, "bad_op");
      endcase
   endfunction

   initial begin
      rst = 1'b1; mem_ready = 1'b0;
      op = '0; func3 = '0; func7 = '0;
      zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      do_reset("por");

      run(mk(7'h33, 3'd0, 7'h00, 0, 0, 1, 2, "add"), 99);
      chk("add_len", 0, exp_q.size(), 4);
      chk("add_aluctl", 2, obs[2].aluctl, 0);
      chk("add_rw_exec", 2, obs[2].regwrite, 0);
      chk("add_rw_wb", 3, obs[3].regwrite, 1);

      run(mk(7'h03, 3'd2, 7'h00, 3, 3, 0, 0, "lw_stall"), 99);
      chk("lw_len", 0, exp_q.size(), 11);
      for (int i = 0; i < 4; i++)
         chk("lw_fetch_req", i, {obs[i].mem_req, obs[i].adrsrc}, 2'b10);
      for (int i = 6; i < 10; i++)
         chk("lw_rd_req", i, {obs[i].mem_req, obs[i].adrsrc}, 2'b11);
      chk("lw_wb", 10, obs[10].regwrite, 1);

      run(mk(7'h63, 3'd0, 7'h00, 0, 0, 5, 5, "beq_t"), 99);
      chk("beq_taken", 2, obs[2].pcwrite, 1);
      run(mk(7'h63, 3'd6, 7'h00, 0, 0, 9, 3, "bltu_nt"), 99);
      chk("bltu_not", 2, obs[2].pcwrite, 0);

      run(mk(7'h6f, 3'd0, 7'h00, 0, 0, 0, 0, "jal"), 99);
      chk("jal_pcw", 2, obs[2].pcwrite, 1);
      chk("jwb", 3, {obs[3].regwrite, obs[3].srca, obs[3].srcb}, 5'b1_01_10);
      run(mk(7'h37, 3'd0, 7'h00, 0, 0, 0, 0, "lui"), 99);
      chk("lui", 2, {obs[2].resultsrc, obs[2].immsrc}, 5'b11_100);

      run(mk(7'h63, 3'd2, 7'h00, 0, 0, 0, 0, "br_f3_010"), 99);
      chk("br_ill", 3, obs[3].illegal, 1);
      chk("br_ill_held", 5, obs[5].illegal, 1);
      run(mk(7'h00, 3'd0, 7'h00, 0, 0, 0, 0, "op0"), 99);
      chk("op0_ill", 2, obs[2].illegal, 1);
      chk("op0_noreq", 4, obs[4].mem_req, 0);

      run(mk(7'h33, 3'd0, 7'h01, 0, 0, 0, 0, "mul"), 99);
      if (MULX) begin
         for (int i = 2; i < 2 + ML; i++)
            chk("mul_ctl", i, obs[i].aluctl, 8);
         chk("mul_wb", 2 + ML, obs[2 + ML].regwrite, 1);
      end else begin
         chk("mul_trap", 3, obs[3].illegal, 1);
      end

      run(mk(7'h03, 3'd2, 7'h00, 0, 5, 0, 0, "lw_abort"), 8);
      do_reset("rst_mid");
      run(mk(7'h33, 3'd0, 7'h00, 0, 0, 1, 2, "add_after"), 99);

      for (int n = 0; n < 120; n++)
         run(rand_instr(), 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
